// File: rtl/memctrl.sv
// Async-SRAM controller: address/write-data latches plus an IDLE-SETUP-STROBE-HOLD strobe sequencer.
// Access takes WAIT_STATES+3 cycles; commands and bus inputs arriving while BUSY are dropped, not queued.
module memctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST_bar,
  input  logic        LOAD_bar,
  input  logic        READ_bar,
  input  logic        WRITE_bar,
  input  logic        INC,
  input  logic        ASSERT_bar,
  input  logic [15:0] BUS_in,
  output logic [15:0] BUS_out,
  output logic        BUSY,
  output logic [15:0] MEM_ADDR,
  input  logic [7:0]  MEM_DATA_in,
  output logic [7:0]  MEM_DATA_out,
  output logic        MEM_OE_bar,
  output logic        MEM_WE_bar
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] LP_LAST_CNT = 4'(WAIT_STATES);

  state_t      r_state;
  logic [15:0] r_addr;
  logic [7:0]  r_rdata;
  logic [7:0]  r_wdata;
  logic        r_is_write;
  logic        r_inc;
  logic [3:0]  r_cnt;
  logic        r_oe_n;
  logic        r_we_n;

  logic        w_rd_cmd;
  logic        w_wr_cmd;

  // Both commands low together is treated as a no-op.
  assign w_rd_cmd = ~READ_bar & WRITE_bar;
  assign w_wr_cmd = ~WRITE_bar & READ_bar;

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      r_state    <= S_IDLE;
      r_addr     <= 16'h0000;
      r_rdata    <= 8'h00;
      r_wdata    <= 8'h00;
      r_is_write <= 1'b0;
      r_inc      <= 1'b0;
      r_cnt      <= 4'd0;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!LOAD_bar) begin
            r_addr <= BUS_in;
          end
          if (w_rd_cmd || w_wr_cmd) begin
            r_state    <= S_SETUP;
            r_is_write <= w_wr_cmd;
            r_inc      <= INC;
            if (w_wr_cmd) begin
              r_wdata <= BUS_in[7:0];
            end
          end
        end
        S_SETUP: begin
          // Exactly one strobe drops here, so OE and WE can never overlap.
          r_cnt   <= 4'd0;
          r_oe_n  <= r_is_write;
          r_we_n  <= ~r_is_write;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (r_cnt == LP_LAST_CNT) begin
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_state <= S_HOLD;
            if (!r_is_write) begin
              r_rdata <= MEM_DATA_in;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HOLD: begin
          if (r_inc) begin
            r_addr <= r_addr + 16'd1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY         = (r_state != S_IDLE);
  assign MEM_ADDR     = r_addr;
  assign MEM_DATA_out = r_wdata;
  assign MEM_OE_bar   = r_oe_n;
  assign MEM_WE_bar   = r_we_n;
  assign BUS_out      = ASSERT_bar ? 16'bz : {8'h00, r_rdata};

endmodule
